// File: rtl/core_pkg.sv
// Shared definitions for the instruction-memory responder: instruction width,
// the filler word for out-of-range fetches, and the boot-load FSM states.
package core_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    // The high byte of each word arrives first, then the low byte.
    // SERVE is entered once the image is complete.
    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        SERVE   = 2'd2
    } load_state_t;

endpackage

// File: rtl/instr_store_1r1w.sv
// DEPTH x 16 instruction store with one synchronous write port and one
// registered read port. Out-of-range reads return NOP_WORD. The array itself
// has no reset so a loaded image survives rst_n; only the read register is reset.
module instr_store_1r1w #(
    parameter int                           DEPTH    = 64,
    parameter int                           ADDR_W   = 16,
    parameter logic [core_pkg::INSTR_W-1:0] NOP_WORD = core_pkg::NOP_WORD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [core_pkg::INSTR_W-1:0] wdata,
    input  logic                         re,
    input  logic [ADDR_W-1:0]            raddr,
    output logic [core_pkg::INSTR_W-1:0] rdata,
    output logic                         rvalid
);
    import core_pkg::*;

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];

    logic raddr_in_range;
    logic waddr_in_range;

    assign raddr_in_range = (raddr < DEPTH_A);
    assign waddr_in_range = (waddr < DEPTH_A);

    // Write port: unreset storage, written only for in-range addresses.
    always_ff @(posedge clk) begin
        if (we && waddr_in_range) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read port: one-cycle registered response; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= NOP_WORD;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= raddr_in_range ? mem[raddr[IDX_W-1:0]] : NOP_WORD;
            end
        end
    end

endmodule

// File: rtl/instruction_memory_responder.sv
// Responder end of the instruction-fetch interface. After reset it assembles
// 16-bit words from a byte-wide boot-load stream (high byte first) into the
// store, then switches to serving one-cycle-latency fetches.
module instruction_memory_responder #(
    parameter int                           DEPTH    = 64,
    parameter int                           ADDR_W   = 16,
    parameter logic [core_pkg::INSTR_W-1:0] NOP_WORD = core_pkg::NOP_WORD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   load_byte,
    input  logic                         load_valid,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_done,
    output logic [ADDR_W-1:0]            load_words,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_ready,
    output logic [core_pkg::INSTR_W-1:0] fetch_data,
    output logic                         fetch_valid
);
    import core_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    load_state_t       state;
    load_state_t       state_next;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] words_inc;
    logic              store_we;
    logic              fetch_accept;

    assign words_inc    = load_words + ADDR_W'(1);
    assign fetch_accept = fetch_req && fetch_ready;

    // Load FSM state register; reset always restarts the load at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. load_valid is only sampled while
    // loading; load_last matters only on the low byte.
    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        load_done   = 1'b0;
        fetch_ready = 1'b0;
        store_we    = 1'b0;
        case (state)
            LOAD_HI: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = LOAD_LO;
                end
            end
            LOAD_LO: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    store_we = 1'b1;
                    if (load_last || (words_inc == DEPTH_A)) begin
                        state_next = SERVE;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            SERVE: begin
                load_done   = 1'b1;
                fetch_ready = 1'b1;
            end
            default: begin
                state_next = LOAD_HI;
            end
        endcase
    end

    // High-byte latch and saturating word counter for the boot load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte    <= 8'h00;
            load_words <= '0;
        end else begin
            if ((state == LOAD_HI) && load_valid) begin
                hi_byte <= load_byte;
            end
            if (store_we && (load_words != DEPTH_A)) begin
                load_words <= words_inc;
            end
        end
    end

    instr_store_1r1w #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP_WORD)
    ) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (store_we),
        .waddr  (load_words),
        .wdata  ({hi_byte, load_byte}),
        .re     (fetch_accept),
        .raddr  (fetch_addr),
        .rdata  (fetch_data),
        .rvalid (fetch_valid)
    );

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench for instruction_memory_responder. Expected fetch
// responses are pushed to a queue when a request is driven and popped by a
// monitor whenever the responder reports fetch_valid.
module tb_instruction_memory_responder;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        load_byte = 8'h00;
    logic              load_valid = 1'b0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W-1:0] load_words;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic [15:0]       fetch_data;
    logic              fetch_valid;

    int          compared_count = 0;
    int          mismatch_count = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model_mem [DEPTH];
    logic [15:0] mon_exp;
    bit          serving = 1'b0;

    instruction_memory_responder #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_byte   (load_byte),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_words  (load_words),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Response monitor: every valid response must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && fetch_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("fetch_data", {16'h0, fetch_data}, {16'h0, mon_exp});
            end
        end
    end

    // Drive one load byte; it stays asserted until the next call or idleLoad.
    task automatic applyStimulus(input logic [7:0] b, input bit last);
        @(negedge clk);
        load_byte  = b;
        load_valid = 1'b1;
        load_last  = last;
    endtask

    // Load gap: valid low while the data and last lines toggle freely.
    task automatic idleLoad();
        @(negedge clk);
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        load_last  = 1'($urandom);
    endtask

    task automatic loadWord(input int idx, input logic [15:0] w, input bit last);
        applyStimulus(w[15:8], 1'b0);
        applyStimulus(w[7:0], last);
        model_mem[idx] = w;
    endtask

    task automatic fetchWord(input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        load_valid = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        if (serving) begin
            exp_q.push_back((addr < ADDR_W'(DEPTH)) ? model_mem[addr] : 16'h0000);
        end
    endtask

    task automatic fetchIdle();
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    // Bounded wait for outstanding responses; leftovers count as a failure.
    task automatic drainCheck();
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        serving    = 1'b0;
        #1;
        checkOutput("rst_load_ready", {31'h0, load_ready}, 32'd1);
        checkOutput("rst_load_done", {31'h0, load_done}, 32'd0);
        checkOutput("rst_load_words", {16'h0, load_words}, 32'd0);
        checkOutput("rst_fetch_ready", {31'h0, fetch_ready}, 32'd0);
        checkOutput("rst_fetch_valid", {31'h0, fetch_valid}, 32'd0);
        checkOutput("rst_fetch_data", {16'h0, fetch_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] gap_words [4];
        gap_words[0] = 16'hBEEF;
        gap_words[1] = 16'h0F1E;
        gap_words[2] = 16'h7C3A;
        gap_words[3] = 16'h9001;

        // Two-word image, then two fetches with latency and hold checks.
        doReset();
        loadWord(0, 16'h1234, 1'b0);
        applyStimulus(8'hAB, 1'b0);
        applyStimulus(8'hCD, 1'b1);
        model_mem[1] = 16'hABCD;
        checkOutput("t1_done_before", {31'h0, load_done}, 32'd0);
        idleLoad();
        serving = 1'b1;
        checkOutput("t1_done_after", {31'h0, load_done}, 32'd1);
        checkOutput("t1_words", {16'h0, load_words}, 32'd2);
        checkOutput("t1_load_ready", {31'h0, load_ready}, 32'd0);
        checkOutput("t1_fetch_ready", {31'h0, fetch_ready}, 32'd1);
        fetchWord(16'd0);
        fetchWord(16'd1);
        checkOutput("t1_lat_valid0", {31'h0, fetch_valid}, 32'd1);
        checkOutput("t1_lat_data0", {16'h0, fetch_data}, 32'h1234);
        fetchIdle();
        checkOutput("t1_lat_valid1", {31'h0, fetch_valid}, 32'd1);
        checkOutput("t1_lat_data1", {16'h0, fetch_data}, 32'hABCD);
        @(negedge clk);
        checkOutput("t1_idle_valid", {31'h0, fetch_valid}, 32'd0);
        checkOutput("t1_idle_hold", {16'h0, fetch_data}, 32'hABCD);
        drainCheck();

        // Fetch held high during load is ignored until SERVE.
        doReset();
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        loadWord(0, 16'h1111, 1'b0);
        checkOutput("t2_fetch_ready", {31'h0, fetch_ready}, 32'd0);
        checkOutput("t2_no_valid_a", {31'h0, fetch_valid}, 32'd0);
        loadWord(1, 16'h2222, 1'b1);
        checkOutput("t2_no_valid_b", {31'h0, fetch_valid}, 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        serving    = 1'b1;
        exp_q.push_back(model_mem[0]);
        checkOutput("t2_no_valid_c", {31'h0, fetch_valid}, 32'd0);
        @(negedge clk);
        fetch_req = 1'b0;
        checkOutput("t2_first_valid", {31'h0, fetch_valid}, 32'd1);
        checkOutput("t2_first_data", {16'h0, fetch_data}, 32'h1111);
        drainCheck();

        // Full-depth load without load_last, then an extra byte is refused.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i) ^ 8'h5A, 8'(i) + 8'h80};
            loadWord(i, w, 1'b0);
        end
        applyStimulus(8'h77, 1'b0);
        checkOutput("t3_load_ready", {31'h0, load_ready}, 32'd0);
        checkOutput("t3_done", {31'h0, load_done}, 32'd1);
        checkOutput("t3_words", {16'h0, load_words}, 32'd64);
        @(negedge clk);
        checkOutput("t3_words_sat", {16'h0, load_words}, 32'd64);
        serving = 1'b1;
        fetchWord(16'd0);
        fetchWord(16'd63);
        fetchWord(16'd64);
        fetchIdle();
        drainCheck();

        // 40-word image, then back-to-back fetches including out-of-range.
        doReset();
        for (int i = 0; i < 40; i++) begin
            w = 16'(i * 16'h0301) ^ 16'hC3A5;
            loadWord(i, w, i == 39);
        end
        @(negedge clk);
        load_valid = 1'b0;
        serving    = 1'b1;
        checkOutput("t4_words", {16'h0, load_words}, 32'd40);
        fetchWord(16'd32);
        fetchWord(16'd2);
        fetchWord(16'd100);
        fetchWord(16'd64);
        fetchWord(16'hFFFF);
        fetchWord(16'd39);
        fetchIdle();
        drainCheck();

        // Reset between high and low byte discards the partial word.
        doReset();
        applyStimulus(8'hFF, 1'b0);
        doReset();
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h78, 1'b1);
        model_mem[0] = 16'h5678;
        @(negedge clk);
        load_valid = 1'b0;
        serving    = 1'b1;
        checkOutput("t5_words", {16'h0, load_words}, 32'd1);
        checkOutput("t5_done", {31'h0, load_done}, 32'd1);
        fetchWord(16'd0);
        fetchIdle();
        drainCheck();

        // Gaps with toggling lines between bytes; load_last on a high byte ignored.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(gap_words[i][15:8], i == 0);
            idleLoad();
            idleLoad();
            checkOutput("t6_hold_ready", {31'h0, load_ready}, 32'd1);
            checkOutput("t6_hold_done", {31'h0, load_done}, 32'd0);
            applyStimulus(gap_words[i][7:0], i == 3);
            model_mem[i] = gap_words[i];
            idleLoad();
        end
        serving = 1'b1;
        checkOutput("t6_words", {16'h0, load_words}, 32'd4);
        checkOutput("t6_done", {31'h0, load_done}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            fetchWord(ADDR_W'(i));
        end
        fetchIdle();
        drainCheck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

endmodule
